// File: rtl/csc_sync_mon_multi.sv
// Frame-marker sync monitor for NLINK CFEB optical links split into two groups (ME1/b, ME1/a).
// Each group arms after TTC resync, then tracks marker agreement, consecutive-bad loss, error counts and culprit links.
module csc_sync_mon_multi #(
    parameter int NLINK    = 7,
    parameter int NSPLIT   = 4,
    parameter int ERRCNT_W = 16,
    parameter int THRESH_W = 4
) (
    input  logic                clock,
    input  logic                global_reset,
    input  logic                ttc_resync,
    input  logic                cnt_clear,
    input  logic [8*NLINK-1:0]  kchar,
    input  logic [NLINK-1:0]    link_good,
    input  logic [NLINK-1:0]    fiber_enable,
    input  logic [NLINK-1:0]    sync_done,
    input  logic [3:0]          arm_dly0,
    input  logic [3:0]          arm_dly1,
    input  logic [THRESH_W-1:0] bad_thresh,
    output logic [1:0]          synced,
    output logic [1:0]          lostsync,
    output logic [ERRCNT_W-1:0] err_cnt0,
    output logic [ERRCNT_W-1:0] err_cnt1,
    output logic [NLINK-1:0]    bad_link_mask,
    output logic [3:0]          mon_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_MON  = 2'd2,
        ST_LOST = 2'd3
    } mon_state_t;

    function automatic logic [NLINK-1:0] grp0_mask_f();
        logic [NLINK-1:0] m;
        for (int i = 0; i < NLINK; i++) begin
            m[i] = (i < NSPLIT);
        end
        return m;
    endfunction

    localparam logic [NLINK-1:0] GRP0_MASK = grp0_mask_f();
    localparam logic [NLINK-1:0] GRP1_MASK = ~GRP0_MASK;

    logic [NLINK-1:0]    lg_r1;
    logic [NLINK-1:0]    lg_r2;
    logic [NLINK-1:0]    skip;
    logic [NLINK-1:0]    valid;
    logic [NLINK-1:0]    culprit;
    logic [7:0]          anchor_k [2];
    logic [1:0]          anchor_found;
    logic [1:0]          bad;
    logic [1:0]          grp_done;
    logic [1:0]          in_mon;
    logic [NLINK-1:0]    mon_mask;
    logic [THRESH_W-1:0] thresh_eff;
    logic [3:0]          arm_dly [2];

    mon_state_t          state_q  [2];
    logic [3:0]          arm_cnt  [2];
    logic [THRESH_W-1:0] cons_cnt [2];
    logic [THRESH_W-1:0] cons_next [2];

    // A link is ignored while idle (FC), unlocked now or two cycles ago, or disabled.
    always_comb begin
        for (int i = 0; i < NLINK; i++) begin
            skip[i]  = (kchar[8*i +: 8] == 8'hFC) || !link_good[i] || !lg_r2[i] || !fiber_enable[i];
            valid[i] = (kchar[8*i+1 +: 4] == 4'hE);
        end
    end

    // Reference marker per group: the lowest-index link that is not skipped.
    always_comb begin
        anchor_found = 2'b00;
        anchor_k[0]  = 8'h00;
        anchor_k[1]  = 8'h00;
        for (int i = 0; i < NLINK; i++) begin
            if (i < NSPLIT) begin
                if (!skip[i] && !anchor_found[0]) begin
                    anchor_found[0] = 1'b1;
                    anchor_k[0]     = kchar[8*i +: 8];
                end
            end else begin
                if (!skip[i] && !anchor_found[1]) begin
                    anchor_found[1] = 1'b1;
                    anchor_k[1]     = kchar[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NLINK; i++) begin
            if (i < NSPLIT) begin
                culprit[i] = !skip[i] && (!valid[i] || (kchar[8*i +: 8] != anchor_k[0]));
            end else begin
                culprit[i] = !skip[i] && (!valid[i] || (kchar[8*i +: 8] != anchor_k[1]));
            end
        end
    end

    always_comb begin
        bad[0]      = |(culprit & GRP0_MASK);
        bad[1]      = |(culprit & GRP1_MASK);
        grp_done[0] = &(sync_done | GRP1_MASK);
        grp_done[1] = &(sync_done | GRP0_MASK);
        in_mon[0]   = (state_q[0] == ST_MON) || (state_q[0] == ST_LOST);
        in_mon[1]   = (state_q[1] == ST_MON) || (state_q[1] == ST_LOST);
        mon_mask    = (in_mon[0] ? GRP0_MASK : '0) | (in_mon[1] ? GRP1_MASK : '0);
        thresh_eff  = (bad_thresh == '0) ? THRESH_W'(1) : bad_thresh;
        arm_dly[0]  = arm_dly0;
        arm_dly[1]  = arm_dly1;
        for (int g = 0; g < 2; g++) begin
            cons_next[g] = (&cons_cnt[g]) ? cons_cnt[g] : cons_cnt[g] + THRESH_W'(1);
        end
    end

    assign mon_state = {state_q[1], state_q[0]};

    // Per-group monitor FSMs; resync restarts them exactly like reset.
    always_ff @(posedge clock) begin
        if (global_reset || ttc_resync) begin
            for (int g = 0; g < 2; g++) begin
                state_q[g]  <= ST_IDLE;
                arm_cnt[g]  <= 4'd0;
                cons_cnt[g] <= '0;
            end
            synced   <= 2'b11;
            lostsync <= 2'b00;
        end else begin
            for (int g = 0; g < 2; g++) begin
                case (state_q[g])
                    ST_IDLE: begin
                        synced[g]   <= 1'b1;
                        lostsync[g] <= 1'b0;
                        cons_cnt[g] <= '0;
                        if (grp_done[g]) begin
                            state_q[g] <= ST_ARM;
                            arm_cnt[g] <= arm_dly[g];
                        end
                    end
                    ST_ARM: begin
                        synced[g]   <= 1'b1;
                        lostsync[g] <= 1'b0;
                        if (!grp_done[g]) begin
                            state_q[g] <= ST_IDLE;
                        end else if (arm_cnt[g] == 4'd0) begin
                            state_q[g] <= ST_MON;
                        end else begin
                            arm_cnt[g] <= arm_cnt[g] - 4'd1;
                        end
                    end
                    ST_MON: begin
                        if (!grp_done[g]) begin
                            state_q[g]  <= ST_IDLE;
                            synced[g]   <= 1'b1;
                            cons_cnt[g] <= '0;
                        end else begin
                            synced[g] <= !bad[g];
                            if (bad[g]) begin
                                cons_cnt[g] <= cons_next[g];
                                if (cons_next[g] >= thresh_eff) begin
                                    state_q[g]  <= ST_LOST;
                                    lostsync[g] <= 1'b1;
                                end
                            end else begin
                                cons_cnt[g] <= '0;
                            end
                        end
                    end
                    ST_LOST: begin
                        if (!grp_done[g]) begin
                            state_q[g]  <= ST_IDLE;
                            synced[g]   <= 1'b1;
                            lostsync[g] <= 1'b0;
                            cons_cnt[g] <= '0;
                        end else begin
                            synced[g]   <= !bad[g];
                            lostsync[g] <= 1'b1;
                        end
                    end
                    default: state_q[g] <= ST_IDLE;
                endcase
            end
        end
    end

    // Link history, error counters and culprit mask; resync leaves the counters alone.
    always_ff @(posedge clock) begin
        if (global_reset) begin
            lg_r1         <= '0;
            lg_r2         <= '0;
            err_cnt0      <= '0;
            err_cnt1      <= '0;
            bad_link_mask <= '0;
        end else begin
            lg_r1 <= link_good;
            lg_r2 <= lg_r1;
            if (!ttc_resync) begin
                if (cnt_clear) begin
                    err_cnt0      <= '0;
                    err_cnt1      <= '0;
                    bad_link_mask <= '0;
                end else begin
                    if (in_mon[0] && bad[0] && !(&err_cnt0)) begin
                        err_cnt0 <= err_cnt0 + ERRCNT_W'(1);
                    end
                    if (in_mon[1] && bad[1] && !(&err_cnt1)) begin
                        err_cnt1 <= err_cnt1 + ERRCNT_W'(1);
                    end
                    bad_link_mask <= bad_link_mask | (culprit & mon_mask);
                end
            end
        end
    end

endmodule

// File: tb/tb_csc_sync_mon_multi.sv
// Directed bench for csc_sync_mon_multi: a vector table for the main scenario plus a
// saturation sequence on a second instance with a 4-bit error counter.
module tb_csc_sync_mon_multi;

    localparam int NLINK    = 7;
    localparam int NSPLIT   = 4;
    localparam int ERRCNT_W = 16;
    localparam int THRESH_W = 4;
    localparam logic [NLINK-1:0] A = 7'h7F;

    logic                clock;
    logic                global_reset;
    logic                ttc_resync;
    logic                cnt_clear;
    logic [8*NLINK-1:0]  kchar;
    logic [NLINK-1:0]    link_good;
    logic [NLINK-1:0]    fiber_enable;
    logic [NLINK-1:0]    sync_done;
    logic [3:0]          arm_dly0;
    logic [3:0]          arm_dly1;
    logic [THRESH_W-1:0] bad_thresh;

    logic [1:0]          synced;
    logic [1:0]          lostsync;
    logic [ERRCNT_W-1:0] err_cnt0;
    logic [ERRCNT_W-1:0] err_cnt1;
    logic [NLINK-1:0]    bad_link_mask;
    logic [3:0]          mon_state;

    logic [1:0]          s_synced;
    logic [1:0]          s_lostsync;
    logic [3:0]          s_err_cnt0;
    logic [3:0]          s_err_cnt1;
    logic [NLINK-1:0]    s_bad_link_mask;
    logic [3:0]          s_mon_state;

    csc_sync_mon_multi #(
        .NLINK(NLINK), .NSPLIT(NSPLIT), .ERRCNT_W(ERRCNT_W), .THRESH_W(THRESH_W)
    ) dut (
        .clock(clock), .global_reset(global_reset), .ttc_resync(ttc_resync),
        .cnt_clear(cnt_clear), .kchar(kchar), .link_good(link_good),
        .fiber_enable(fiber_enable), .sync_done(sync_done), .arm_dly0(arm_dly0),
        .arm_dly1(arm_dly1), .bad_thresh(bad_thresh), .synced(synced),
        .lostsync(lostsync), .err_cnt0(err_cnt0), .err_cnt1(err_cnt1),
        .bad_link_mask(bad_link_mask), .mon_state(mon_state)
    );

    csc_sync_mon_multi #(
        .NLINK(NLINK), .NSPLIT(NSPLIT), .ERRCNT_W(4), .THRESH_W(THRESH_W)
    ) dut_small (
        .clock(clock), .global_reset(global_reset), .ttc_resync(ttc_resync),
        .cnt_clear(cnt_clear), .kchar(kchar), .link_good(link_good),
        .fiber_enable(fiber_enable), .sync_done(sync_done), .arm_dly0(arm_dly0),
        .arm_dly1(arm_dly1), .bad_thresh(bad_thresh), .synced(s_synced),
        .lostsync(s_lostsync), .err_cnt0(s_err_cnt0), .err_cnt1(s_err_cnt1),
        .bad_link_mask(s_bad_link_mask), .mon_state(s_mon_state)
    );

    // Clock / reset
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [8*NLINK-1:0]  kchar;
        logic [NLINK-1:0]    lg;
        logic [NLINK-1:0]    fe;
        logic [NLINK-1:0]    done;
        logic                rst;
        logic                rs;
        logic                clr;
        logic [THRESH_W-1:0] thr;
        logic [1:0]          exp_synced;
        logic [1:0]          exp_lost;
        logic [15:0]         exp_e0;
        logic [15:0]         exp_e1;
        logic [NLINK-1:0]    exp_mask;
        logic [3:0]          exp_state;
    } vec_t;

    vec_t vecs [$];
    int   n_checks;
    int   n_fail;

    function automatic logic [8*NLINK-1:0] kc(input int idx, input logic [7:0] val);
        logic [8*NLINK-1:0] r;
        r = {NLINK{8'hBC}};
        if (idx >= 0) r[8*idx +: 8] = val;
        return r;
    endfunction

    task automatic add(input logic [8*NLINK-1:0] k, input logic [NLINK-1:0] lg,
                       input logic [NLINK-1:0] fe, input logic [NLINK-1:0] done,
                       input logic rst, input logic rs, input logic clr,
                       input logic [THRESH_W-1:0] thr, input logic [1:0] syn,
                       input logic [1:0] lost, input logic [15:0] e0, input logic [15:0] e1,
                       input logic [NLINK-1:0] mask, input logic [3:0] st);
        vec_t v;
        v.kchar = k; v.lg = lg; v.fe = fe; v.done = done;
        v.rst = rst; v.rs = rs; v.clr = clr; v.thr = thr;
        v.exp_synced = syn; v.exp_lost = lost; v.exp_e0 = e0; v.exp_e1 = e1;
        v.exp_mask = mask; v.exp_state = st;
        vecs.push_back(v);
    endtask

    // Scoreboard compare
    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (step %0d): got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Driver
    task automatic apply(input int idx, input vec_t v);
        kchar        = v.kchar;
        link_good    = v.lg;
        fiber_enable = v.fe;
        sync_done    = v.done;
        global_reset = v.rst;
        ttc_resync   = v.rs;
        cnt_clear    = v.clr;
        bad_thresh   = v.thr;
        tick();
        check("synced",        idx, 32'(synced),        32'(v.exp_synced));
        check("lostsync",      idx, 32'(lostsync),      32'(v.exp_lost));
        check("err_cnt0",      idx, 32'(err_cnt0),      32'(v.exp_e0));
        check("err_cnt1",      idx, 32'(err_cnt1),      32'(v.exp_e1));
        check("bad_link_mask", idx, 32'(bad_link_mask), 32'(v.exp_mask));
        check("mon_state",     idx, 32'(mon_state),     32'(v.exp_state));
    endtask

    initial begin
        logic [8*NLINK-1:0] bc;
        n_checks     = 0;
        n_fail       = 0;
        bc           = kc(-1, 8'h00);
        global_reset = 1'b1;
        ttc_resync   = 1'b0;
        cnt_clear    = 1'b0;
        kchar        = bc;
        link_good    = A;
        fiber_enable = A;
        sync_done    = '0;
        arm_dly0     = 4'd3;
        arm_dly1     = 4'd0;
        bad_thresh   = 4'd3;

        //   kchar            lg      fe      done    rst   rs    clr   thr   syn    lost   e0     e1     mask    st
        add(bc,              A,      A,      7'h00,  1'b1, 1'b0, 1'b0, 4'd3, 2'b11, 2'b00, 16'd0, 16'd0, 7'h00, 4'h0); // 0 reset
        add(bc,              A,      A,      A,      1'b0, 1'b0, 1'b0, 4'd3, 2'b11, 2'b00, 16'd0, 16'd0, 7'h00, 4'h5); // 1 both ARM
        add(bc,              A,      A,      A,      1'b0, 1'b0, 1'b0, 4'd3, 2'b11, 2'b00, 16'd0, 16'd0, 7'h00, 4'h9); // 2 g1 MON (dly 0)
        add(bc,              A,      A,      A,      1'b0, 1'b0, 1'b0, 4'd3, 2'b11, 2'b00, 16'd0, 16'd0, 7'h00, 4'h9);
        add(bc,              A,      A,      A,      1'b0, 1'b0, 1'b0, 4'd3, 2'b11, 2'b00, 16'd0, 16'd0, 7'h00, 4'h9);
        add(bc,              A,      A,      A,      1'b0, 1'b0, 1'b0, 4'd3, 2'b11, 2'b00, 16'd0, 16'd0, 7'h00, 4'hA); // 5 g0 MON after 4 ARM
        add(bc,              A,      A,      A,      1'b0, 1'b0, 1'b0, 4'd3, 2'b11, 2'b00, 16'd0, 16'd0, 7'h00, 4'hA);
        add(kc(2, 8'h1C),    A,      A,      A,      1'b0, 1'b0, 1'b0, 4'd3, 2'b10, 2'b00, 16'd1, 16'd0, 7'h04, 4'hA); // 7 link2 mismatch
        add(kc(2, 8'h1C),    A,      A,      A,      1'b0, 1'b0, 1'b0, 4'd3, 2'b10, 2'b00, 16'd2, 16'd0, 7'h04, 4'hA);
        add(bc,              A,      A,      A,      1'b0, 1'b0, 1'b0, 4'd3, 2'b11, 2'b00, 16'd2, 16'd0, 7'h04, 4'hA);
        add(bc,              A,      A,      A,      1'b0, 1'b0, 1'b0, 4'd3, 2'b11, 2'b00, 16'd2, 16'd0, 7'h04, 4'hA);
        add(kc(5, 8'h3C),    A,      A,      A,      1'b0, 1'b0, 1'b0, 4'd3, 2'b01, 2'b00, 16'd2, 16'd1, 7'h24, 4'hA); // 11 link5 mismatch
        add(kc(5, 8'h3C),    A,      A,      A,      1'b0, 1'b0, 1'b0, 4'd3, 2'b01, 2'b00, 16'd2, 16'd2, 7'h24, 4'hA);
        add(kc(5, 8'h3C),    A,      A,      A,      1'b0, 1'b0, 1'b0, 4'd3, 2'b01, 2'b10, 16'd2, 16'd3, 7'h24, 4'hE); // 13 g1 LOST
        add(bc,              A,      A,      A,      1'b0, 1'b0, 1'b0, 4'd3, 2'b11, 2'b10, 16'd2, 16'd3, 7'h24, 4'hE);
        add(bc,              A,      A,      A,      1'b0, 1'b0, 1'b0, 4'd3, 2'b11, 2'b10, 16'd2, 16'd3, 7'h24, 4'hE);
        add(kc(4, 8'hF7),    A,      A,      A,      1'b0, 1'b0, 1'b0, 4'd3, 2'b01, 2'b10, 16'd2, 16'd4, 7'h74, 4'hE); // 16 bad reference link
        add(kc(1, 8'hF7),    A,      7'h7D,  A,      1'b0, 1'b0, 1'b0, 4'd3, 2'b11, 2'b10, 16'd2, 16'd4, 7'h74, 4'hE); // 17 link1 disabled
        add(kc(1, 8'hF7),    A,      7'h7D,  A,      1'b0, 1'b0, 1'b0, 4'd3, 2'b11, 2'b10, 16'd2, 16'd4, 7'h74, 4'hE);
        add(kc(1, 8'hF7),    7'h7D,  A,      A,      1'b0, 1'b0, 1'b0, 4'd3, 2'b11, 2'b10, 16'd2, 16'd4, 7'h74, 4'hE); // 19 link_good low
        add(kc(1, 8'hF7),    7'h7D,  A,      A,      1'b0, 1'b0, 1'b0, 4'd3, 2'b11, 2'b10, 16'd2, 16'd4, 7'h74, 4'hE);
        add(kc(1, 8'hF7),    A,      A,      A,      1'b0, 1'b0, 1'b0, 4'd3, 2'b11, 2'b10, 16'd2, 16'd4, 7'h74, 4'hE); // 21 lg_r2 still low
        add(kc(1, 8'hF7),    A,      A,      A,      1'b0, 1'b0, 1'b0, 4'd3, 2'b11, 2'b10, 16'd2, 16'd4, 7'h74, 4'hE);
        add(bc,              A,      A,      A,      1'b0, 1'b0, 1'b0, 4'd3, 2'b11, 2'b10, 16'd2, 16'd4, 7'h74, 4'hE);
        add(kc(1, 8'hF7),    A,      A,      A,      1'b0, 1'b0, 1'b0, 4'd3, 2'b10, 2'b10, 16'd3, 16'd4, 7'h76, 4'hE); // 24 link1 live again
        add(bc,              A,      A,      A,      1'b0, 1'b0, 1'b0, 4'd3, 2'b11, 2'b10, 16'd3, 16'd4, 7'h76, 4'hE);
        add(bc,              A,      A,      A,      1'b0, 1'b1, 1'b0, 4'd3, 2'b11, 2'b00, 16'd3, 16'd4, 7'h76, 4'h0); // 26 ttc_resync
        add(bc,              A,      A,      A,      1'b0, 1'b0, 1'b1, 4'd3, 2'b11, 2'b00, 16'd0, 16'd0, 7'h00, 4'h5); // 27 cnt_clear
        add(bc,              A,      A,      A,      1'b0, 1'b0, 1'b0, 4'd3, 2'b11, 2'b00, 16'd0, 16'd0, 7'h00, 4'h9);
        add(bc,              A,      A,      A,      1'b0, 1'b0, 1'b0, 4'd3, 2'b11, 2'b00, 16'd0, 16'd0, 7'h00, 4'h9);
        add(bc,              A,      A,      A,      1'b0, 1'b0, 1'b0, 4'd3, 2'b11, 2'b00, 16'd0, 16'd0, 7'h00, 4'h9);
        add(bc,              A,      A,      A,      1'b0, 1'b0, 1'b0, 4'd3, 2'b11, 2'b00, 16'd0, 16'd0, 7'h00, 4'hA);
        add(kc(2, 8'h1C),    A,      A,      A,      1'b0, 1'b0, 1'b1, 4'd3, 2'b10, 2'b00, 16'd0, 16'd0, 7'h00, 4'hA); // 32 clear beats bad
        add(kc(2, 8'h1C),    A,      A,      A,      1'b0, 1'b0, 1'b0, 4'd3, 2'b10, 2'b00, 16'd1, 16'd0, 7'h04, 4'hA);
        add(kc(2, 8'h1C),    A,      A,      A,      1'b0, 1'b0, 1'b0, 4'd3, 2'b10, 2'b01, 16'd2, 16'd0, 7'h04, 4'hB); // 34 g0 LOST
        add(bc,              A,      A,      7'h7E,  1'b0, 1'b0, 1'b0, 4'd3, 2'b11, 2'b00, 16'd2, 16'd0, 7'h04, 4'h8); // 35 done drop in LOST
        add(bc,              A,      A,      A,      1'b0, 1'b0, 1'b0, 4'd3, 2'b11, 2'b00, 16'd2, 16'd0, 7'h04, 4'h9);
        add(kc(6, 8'h5C),    A,      A,      A,      1'b0, 1'b0, 1'b0, 4'd0, 2'b01, 2'b10, 16'd2, 16'd1, 7'h44, 4'hD); // 37 thresh 0 acts as 1
        add(bc,              A,      A,      A,      1'b0, 1'b0, 1'b0, 4'd3, 2'b11, 2'b10, 16'd2, 16'd1, 7'h44, 4'hD);
        add(bc,              A,      A,      7'h77,  1'b0, 1'b0, 1'b0, 4'd3, 2'b11, 2'b10, 16'd2, 16'd1, 7'h44, 4'hC); // 39 done drop in ARM
        add(bc,              A,      A,      A,      1'b0, 1'b0, 1'b0, 4'd3, 2'b11, 2'b10, 16'd2, 16'd1, 7'h44, 4'hD);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(i, vecs[i]);
        end

        // Error counter saturation: 4-bit instance must stick at 15, 16-bit keeps counting.
        global_reset = 1'b1;
        ttc_resync   = 1'b0;
        cnt_clear    = 1'b0;
        sync_done    = '0;
        link_good    = A;
        fiber_enable = A;
        kchar        = bc;
        bad_thresh   = 4'd3;
        tick();
        check("sat_reset_err", 0, 32'(s_err_cnt0), 32'd0);
        global_reset = 1'b0;
        sync_done    = A;
        repeat (5) tick();
        check("sat_state_main",  0, 32'(mon_state),   32'hA);
        check("sat_state_small", 0, 32'(s_mon_state), 32'hA);
        for (int n = 1; n <= 17; n++) begin
            kchar = kc(2, 8'h1C);
            tick();
            check("sat_err_small", n, 32'(s_err_cnt0), 32'((n > 15) ? 15 : n));
            check("sat_err_main",  n, 32'(err_cnt0),   32'(n));
        end
        check("sat_lost_small", 0, 32'(s_lostsync), 32'b01);
        kchar     = bc;
        cnt_clear = 1'b1;
        tick();
        check("sat_clear_small", 0, 32'(s_err_cnt0), 32'd0);
        check("sat_clear_main",  0, 32'(err_cnt0),   32'd0);
        cnt_clear = 1'b0;

        // Final report
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
